// File: rtl/axi_lite_reg_slave.sv
// AXI-lite register slave: two RW operands, a RO sum and a RO count of
// successful writes. Write and read channels are fully independent.
module axi_lite_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int BASE_ADDR  = 0
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(12);

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    // register index within the 16-byte window (offset[3:2])
    localparam logic [1:0] IDX_REG0 = 2'd0;
    localparam logic [1:0] IDX_REG1 = 2'd1;
    localparam logic [1:0] IDX_SUM  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  aw_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic                  w_held_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]     wstrb_q;

    logic                  bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q,  bresp_d;

    logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
    logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
    logic [DATA_WIDTH-1:0] wcnt_q, wcnt_d;

    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q,  rresp_d;

    // ------------------------------------------------------------------
    // Handshakes and decode
    // ------------------------------------------------------------------
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic commit;

    logic [ADDR_WIDTH-1:0] wr_off;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  wr_err;
    logic                  rd_err;
    logic [1:0]            wr_idx;
    logic [1:0]            rd_idx;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] rd_mux;

    // top strobe bit exists only to match the bus width
    logic unused_strb_msb;
    assign unused_strb_msb = s0_axi_wstrb[NBYTES];

    assign s0_axi_awready = ~aw_held_q;
    assign s0_axi_wready  = ~w_held_q;
    assign s0_axi_arready = ~rvalid_q;

    assign aw_hs = s0_axi_awvalid & ~aw_held_q;
    assign w_hs  = s0_axi_wvalid  & ~w_held_q;
    assign ar_hs = s0_axi_arvalid & ~rvalid_q;
    assign b_hs  = bvalid_q & s0_axi_bready;
    assign r_hs  = rvalid_q & s0_axi_rready;

    // a pending response blocks the next commit until it is accepted
    assign commit = aw_held_q & w_held_q & ~bvalid_q;

    assign wr_off = awaddr_q - BASE;
    assign rd_off = s0_axi_araddr - BASE;
    assign wr_idx = wr_off[3:2];
    assign rd_idx = rd_off[3:2];

    assign sum = reg0_q + reg1_q;

    // SUM and WCNT (idx[1] set) are read-only, so writing them is an error
    assign wr_err = (awaddr_q < BASE) | (wr_off > LAST_OFF) |
                    (awaddr_q[1:0] != 2'b00) | wr_idx[1];

    assign rd_err = (s0_axi_araddr < BASE) | (rd_off > LAST_OFF) |
                    (s0_axi_araddr[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // capture address and data independently; both release on commit
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s0_axi_awaddr;
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end

            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s0_axi_wdata;
                wstrb_q  <= s0_axi_wstrb[NBYTES-1:0];
            end else if (commit) begin
                w_held_q <= 1'b0;
            end
        end
    end

    // register-file update: byte-enabled write and write counter
    always_comb begin
        reg0_d = reg0_q;
        reg1_d = reg1_q;
        wcnt_d = wcnt_q;
        if (commit && !wr_err) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wstrb_q[i]) begin
                    if (wr_idx == IDX_REG0) begin
                        reg0_d[8*i +: 8] = wdata_q[8*i +: 8];
                    end else begin
                        reg1_d[8*i +: 8] = wdata_q[8*i +: 8];
                    end
                end
            end
            wcnt_d = wcnt_q + DATA_WIDTH'(1);
        end
    end

    // write response: raised by a commit, dropped by the B handshake
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end
    end

    // register file and write response state
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            reg0_q   <= '0;
            reg1_q   <= '0;
            wcnt_q   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            reg0_q   <= reg0_d;
            reg1_q   <= reg1_d;
            wcnt_q   <= wcnt_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // read mux works on current register contents, so a read that
    // coincides with a commit returns the pre-commit value
    always_comb begin
        rd_mux = wcnt_q;
        case (rd_idx)
            IDX_REG0: rd_mux = reg0_q;
            IDX_REG1: rd_mux = reg1_q;
            IDX_SUM:  rd_mux = sum;
            default:  rd_mux = wcnt_q;
        endcase
    end

    // read response: loaded on AR handshake, held until R handshake
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? '0 : rd_mux;
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    // read response state
    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    assign s0_axi_bvalid = bvalid_q;
    assign s0_axi_bresp  = bresp_q;
    assign s0_axi_rvalid = rvalid_q;
    assign s0_axi_rdata  = rdata_q;
    assign s0_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: two instances (base 0x00 and 0x10) driven
// by directed scenarios and random transactions against a register-map model.
module tb_axi_lite_reg_slave;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [4:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [2:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [7:0]  araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [2:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(0)
    ) u_dut0 (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr[0]), .s0_axi_awvalid(awvalid[0]), .s0_axi_awready(awready[0]),
        .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
        .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]), .s0_axi_bready(bready[0]),
        .s0_axi_araddr(araddr[0]), .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]),
        .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0])
    );

    axi_lite_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(16)
    ) u_dut1 (
        .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
        .s0_axi_awaddr(awaddr[1]), .s0_axi_awvalid(awvalid[1]), .s0_axi_awready(awready[1]),
        .s0_axi_wdata(wdata[1]), .s0_axi_wstrb(wstrb[1]), .s0_axi_wvalid(wvalid[1]), .s0_axi_wready(wready[1]),
        .s0_axi_bresp(bresp[1]), .s0_axi_bvalid(bvalid[1]), .s0_axi_bready(bready[1]),
        .s0_axi_araddr(araddr[1]), .s0_axi_arvalid(arvalid[1]), .s0_axi_arready(arready[1]),
        .s0_axi_rdata(rdata[1]), .s0_axi_rresp(rresp[1]), .s0_axi_rvalid(rvalid[1]), .s0_axi_rready(rready[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // register-map model: operands and successful-write count per instance
    logic [31:0] m_reg [2][2];
    logic [31:0] m_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int base_of(input int d);
        return (d == 1) ? 16 : 0;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_reg[d][0] = '0;
            m_reg[d][1] = '0;
            m_cnt[d]    = '0;
        end
    endtask

    // applies a write to the model and returns the response it deserves
    function automatic logic [2:0] m_write(input int d, input logic [7:0] addr,
                                           input logic [31:0] data, input logic [4:0] strb);
        int off;
        int idx;
        off = int'(addr) - base_of(d);
        if (off < 0 || off > 7 || addr[1:0] != 2'b00) return 3'd2;
        idx = off / 4;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m_reg[d][idx][8*b +: 8] = data[8*b +: 8];
        m_cnt[d] = m_cnt[d] + 32'd1;
        return 3'd0;
    endfunction

    task automatic m_read(input int d, input logic [7:0] addr,
                          output logic [31:0] data, output logic [2:0] resp);
        int off;
        off  = int'(addr) - base_of(d);
        data = '0;
        resp = 3'd2;
        if (off >= 0 && off <= 12 && addr[1:0] == 2'b00) begin
            resp = 3'd0;
            case (off / 4)
                0:       data = m_reg[d][0];
                1:       data = m_reg[d][1];
                2:       data = m_reg[d][0] + m_reg[d][1];
                default: data = m_cnt[d];
            endcase
        end
    endtask

    task automatic write_txn(input int d, input logic [7:0] addr, input logic [31:0] data,
                             input logic [4:0] strb, output logic [2:0] resp);
        int n;
        bit aw_done, w_done, aw_take, w_take;
        @(negedge clk);
        awaddr[d] = addr; awvalid[d] = 1'b1;
        wdata[d]  = data; wstrb[d]   = strb; wvalid[d] = 1'b1;
        n = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_take = awvalid[d] && awready[d];
            w_take  = wvalid[d] && wready[d];
            @(negedge clk);
            n++;
            if (aw_take) begin awvalid[d] = 1'b0; aw_done = 1; end
            if (w_take)  begin wvalid[d]  = 1'b0; w_done  = 1; end
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        check("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
        n = 0;
        while (!bvalid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_wait", 32'(bvalid[d]), 32'd1);
        resp = bresp[d];
        @(negedge clk);
    endtask

    task automatic read_txn(input int d, input logic [7:0] addr,
                            output logic [31:0] data, output logic [2:0] resp);
        int n;
        bit taken, t;
        @(negedge clk);
        araddr[d] = addr; arvalid[d] = 1'b1;
        n = 0; taken = 0;
        while (!taken && n < 20) begin
            t = arready[d];
            @(negedge clk);
            n++;
            if (t) begin arvalid[d] = 1'b0; taken = 1; end
        end
        arvalid[d] = 1'b0;
        check("ar_accept", 32'(taken), 32'd1);
        n = 0;
        while (!rvalid[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rvalid_wait", 32'(rvalid[d]), 32'd1);
        data = rdata[d];
        resp = rresp[d];
        @(negedge clk);
    endtask

    task automatic wr_chk(input int d, input logic [7:0] addr, input logic [31:0] data,
                          input logic [4:0] strb, output logic [2:0] resp);
        logic [2:0] exp;
        write_txn(d, addr, data, strb, resp);
        exp = m_write(d, addr, data, strb);
        check("bresp", 32'(resp), 32'(exp));
    endtask

    task automatic rd_chk(input int d, input logic [7:0] addr,
                          output logic [31:0] data, output logic [2:0] resp);
        logic [31:0] ed;
        logic [2:0]  er;
        read_txn(d, addr, data, resp);
        m_read(d, addr, ed, er);
        check("rdata", data, ed);
        check("rresp", 32'(resp), 32'(er));
    endtask

    task automatic reset_outputs_chk();
        for (int d = 0; d < 2; d++) begin
            check("rst_awready", 32'(awready[d]), 32'd1);
            check("rst_wready",  32'(wready[d]),  32'd1);
            check("rst_arready", 32'(arready[d]), 32'd1);
            check("rst_bvalid",  32'(bvalid[d]),  32'd0);
            check("rst_rvalid",  32'(rvalid[d]),  32'd0);
            check("rst_bresp",   32'(bresp[d]),   32'd0);
            check("rst_rresp",   32'(rresp[d]),   32'd0);
            check("rst_rdata",   rdata[d],        32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dt, prev;
        logic [2:0]  rs;
        int          d;
        logic [7:0]  a;

        for (int i = 0; i < 2; i++) begin
            awaddr[i] = '0; awvalid[i] = 1'b0;
            wdata[i]  = '0; wstrb[i]   = '0; wvalid[i] = 1'b0;
            bready[i] = 1'b1;
            araddr[i] = '0; arvalid[i] = 1'b0;
            rready[i] = 1'b1;
        end
        m_reset();

        repeat (3) @(negedge clk);
        reset_outputs_chk();
        rst_n = 1'b1;
        @(negedge clk);
        reset_outputs_chk();

        // basic write then read back
        wr_chk(0, 8'h00, 32'h11223344, 5'h0F, rs);
        check("wr0_okay", 32'(rs), 32'd0);
        rd_chk(0, 8'h00, dt, rs);
        check("rd0_val", dt, 32'h11223344);
        check("rd0_okay", 32'(rs), 32'd0);
        rd_chk(0, 8'h0C, dt, rs);
        check("wcnt_one", dt, 32'd1);

        // single-byte strobe
        wr_chk(0, 8'h04, 32'hFFFFFFFF, 5'h0F, rs);
        wr_chk(0, 8'h04, 32'h000000AA, 5'h01, rs);
        rd_chk(0, 8'h04, dt, rs);
        check("strb_byte0", dt, 32'hFFFFFFAA);

        // sum wraps modulo 2^32
        wr_chk(0, 8'h00, 32'hFFFFFFFF, 5'h0F, rs);
        wr_chk(0, 8'h04, 32'h00000002, 5'h0F, rs);
        rd_chk(0, 8'h08, dt, rs);
        check("sum_wrap", dt, 32'h00000001);

        // decode errors change nothing
        wr_chk(0, 8'h08, 32'h5, 5'h0F, rs);
        check("wr_sum_err", 32'(rs), 32'd2);
        wr_chk(0, 8'h02, 32'h5, 5'h0F, rs);
        check("wr_unaligned_err", 32'(rs), 32'd2);
        wr_chk(0, 8'h10, 32'h5, 5'h0F, rs);
        check("wr_range_err", 32'(rs), 32'd2);
        rd_chk(0, 8'h08, dt, rs);
        check("sum_kept", dt, 32'h00000001);
        rd_chk(0, 8'h0C, dt, rs);
        check("wcnt_kept", dt, 32'd5);
        rd_chk(0, 8'h10, dt, rs);
        check("rd_range_resp", 32'(rs), 32'd2);
        check("rd_range_data", dt, 32'd0);

        // instance at base 0x10
        wr_chk(1, 8'h10, 32'h5, 5'h0F, rs);
        check("b16_wr_okay", 32'(rs), 32'd0);
        rd_chk(1, 8'h10, dt, rs);
        check("b16_rd_val", dt, 32'h5);
        wr_chk(1, 8'h00, 32'h7, 5'h0F, rs);
        check("b16_below_err", 32'(rs), 32'd2);

        // W three cycles ahead of AW, B stalled, second write queued
        @(negedge clk);
        bready[0] = 1'b0;
        wdata[0] = 32'hCAFEF00D; wstrb[0] = 5'h0F; wvalid[0] = 1'b1;
        check("wready_idle", 32'(wready[0]), 32'd1);
        @(negedge clk);
        wvalid[0] = 1'b0;
        check("wready_held", 32'(wready[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("bvalid_no_aw", 32'(bvalid[0]), 32'd0);
        end
        awaddr[0] = 8'h04; awvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0;
        check("awready_held", 32'(awready[0]), 32'd0);
        check("bvalid_aw_edge", 32'(bvalid[0]), 32'd0);
        @(negedge clk);
        check("bvalid_next_edge", 32'(bvalid[0]), 32'd1);
        check("bresp_first", 32'(bresp[0]), 32'd0);
        void'(m_write(0, 8'h04, 32'hCAFEF00D, 5'h0F));
        check("awready_after_commit", 32'(awready[0]), 32'd1);
        awaddr[0] = 8'h00; awvalid[0] = 1'b1;
        wdata[0] = 32'h12345678; wstrb[0] = 5'h13; wvalid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            awvalid[0] = 1'b0;
            wvalid[0]  = 1'b0;
            check("stall_awready", 32'(awready[0]), 32'd0);
            check("stall_bvalid",  32'(bvalid[0]),  32'd1);
            check("stall_bresp",   32'(bresp[0]),   32'd0);
        end
        bready[0] = 1'b1;
        @(negedge clk);
        check("bvalid_cleared", 32'(bvalid[0]), 32'd0);
        @(negedge clk);
        check("second_commit", 32'(bvalid[0]), 32'd1);
        check("second_bresp", 32'(bresp[0]), 32'd0);
        void'(m_write(0, 8'h00, 32'h12345678, 5'h13));
        @(negedge clk);
        check("second_b_done", 32'(bvalid[0]), 32'd0);
        rd_chk(0, 8'h04, dt, rs);
        rd_chk(0, 8'h00, dt, rs);
        rd_chk(0, 8'h0C, dt, rs);
        check("wcnt_stall", dt, 32'd7);

        // read coinciding with commit returns the old value
        prev = m_reg[0][0];
        @(negedge clk);
        awaddr[0] = 8'h00; awvalid[0] = 1'b1;
        wdata[0] = 32'hA5A5A5A5; wstrb[0] = 5'h0F; wvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        araddr[0] = 8'h00; arvalid[0] = 1'b1;
        check("coinc_bvalid_pre", 32'(bvalid[0]), 32'd0);
        @(negedge clk);
        arvalid[0] = 1'b0;
        check("coinc_rvalid", 32'(rvalid[0]), 32'd1);
        check("coinc_rdata_old", rdata[0], prev);
        check("coinc_bvalid", 32'(bvalid[0]), 32'd1);
        void'(m_write(0, 8'h00, 32'hA5A5A5A5, 5'h0F));
        @(negedge clk);
        rd_chk(0, 8'h00, dt, rs);

        // random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            d = int'($urandom_range(0, 1));
            a = 8'($urandom_range(0, (d == 1) ? 8'h27 : 8'h17));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1)
                wr_chk(d, a, $urandom, 5'($urandom_range(0, 31)), rs);
            else
                rd_chk(d, a, dt, rs);
        end

        // reset between AW capture and W drops the write
        @(negedge clk);
        awaddr[0] = 8'h00; awvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0;
        check("pre_rst_aw_held", 32'(awready[0]), 32'd0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        reset_outputs_chk();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_bvalid", 32'(bvalid[0]), 32'd0);
        end
        check("post_rst_awready", 32'(awready[0]), 32'd1);
        rd_chk(0, 8'h00, dt, rs);
        check("post_rst_reg0", dt, 32'd0);
        rd_chk(0, 8'h04, dt, rs);
        check("post_rst_reg1", dt, 32'd0);
        wr_chk(0, 8'h04, 32'h0BADBEEF, 5'h0F, rs);
        rd_chk(0, 8'h0C, dt, rs);
        check("post_rst_wcnt", dt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
